// File: rtl/cpp_internal_double_to_int_convert.sv
// Iterative IEEE-754 double to saturating signed integer converter (truncate toward zero).
// A level change on update_in starts a conversion; update_out mirrors the consumed level when out is valid.
module cpp_internal_double_to_int_convert #(
  parameter int OUT_WIDTH  = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          in,
  input  logic                 update_in,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 update_out,
  output logic                 busy,
  output logic                 overflow,
  output logic                 invalid
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  localparam logic signed [12:0] K_MAX   = 13'(OUT_WIDTH - 1);
  localparam logic [52:0]        MAG_POS = (53'd1 << (OUT_WIDTH - 1)) - 53'd1;
  localparam logic [52:0]        MAG_NEG = 53'd1 << (OUT_WIDTH - 1);
  localparam logic [6:0]         STEP    = 7'(SHIFT_STEP);

  state_t      state_q, state_d;
  logic        upd_seen;
  logic        sign_q;
  logic [52:0] sig_q;
  logic [5:0]  s_q;
  logic        pend_ovf, pend_inv;

  // Exponent/mantissa decode of the live input; only used on the capture edge.
  logic               [10:0] exp_in;
  logic               [51:0] mant_in;
  logic signed        [12:0] k;
  logic                      is_nan, is_inf, k_neg, k_big, exact_min, fast;
  logic               [52:0] fast_mag;
  logic                      fast_ovf;
  logic                      pending, last_step;
  logic               [6:0]  step;
  logic [OUT_WIDTH-1:0]      mag_w;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    exp_in    = in[62:52];
    mant_in   = in[51:0];
    k         = $signed({2'b00, exp_in}) - 13'sd1023;
    is_nan    = (exp_in == 11'h7FF) && (mant_in != 52'd0);
    is_inf    = (exp_in == 11'h7FF) && (mant_in == 52'd0);
    k_neg     = k[12];
    k_big     = !k_neg && (k >= K_MAX);
    exact_min = in[63] && (k == K_MAX) && (mant_in == 52'd0);
    fast      = is_nan || is_inf || k_neg || k_big;
    fast_mag  = 53'd0;
    fast_ovf  = 1'b0;
    if (is_nan || k_neg) begin
      fast_mag = 53'd0;
    end else if (exact_min) begin
      fast_mag = MAG_NEG;
    end else if (is_inf || k_big) begin
      fast_mag = in[63] ? MAG_NEG : MAG_POS;
      fast_ovf = 1'b1;
    end
    pending   = (update_in != upd_seen);
    last_step = ({1'b0, s_q} <= STEP);
    step      = last_step ? {1'b0, s_q} : STEP;
    mag_w     = sig_q[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending) state_d = fast ? FINISH : SHIFT;
      SHIFT:   if (last_step) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out        <= '0;
      update_out <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      invalid    <= 1'b0;
      upd_seen   <= 1'b0;
      sign_q     <= 1'b0;
      sig_q      <= '0;
      s_q        <= '0;
      pend_ovf   <= 1'b0;
      pend_inv   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending) begin
            upd_seen <= update_in;
            busy     <= 1'b1;
            sign_q   <= in[63];
            if (fast) begin
              sig_q    <= fast_mag;
              s_q      <= '0;
              pend_ovf <= fast_ovf;
              pend_inv <= is_nan;
            end else begin
              // k is 0..OUT_WIDTH-2 here, so the remaining shift 52-k is 1..52.
              sig_q    <= {1'b1, mant_in};
              s_q      <= 6'd52 - 6'(k[5:0]);
              pend_ovf <= 1'b0;
              pend_inv <= 1'b0;
            end
          end
        end
        SHIFT: begin
          sig_q <= sig_q >> step;
          s_q   <= s_q - step[5:0];
        end
        FINISH: begin
          // Magnitude never exceeds 2^(OUT_WIDTH-1), so the truncated negate is exact.
          out        <= sign_q ? (~mag_w + OUT_WIDTH'(1)) : mag_w;
          overflow   <= pend_ovf;
          invalid    <= pend_inv;
          update_out <= upd_seen;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpp_internal_double_to_int_convert.sv
// Directed bench for cpp_internal_double_to_int_convert with hand-computed expected results.
module tb_cpp_internal_double_to_int_convert;

  logic        clk;
  logic        rst_n;
  logic [63:0] in;
  logic        update_in;
  logic [31:0] out;
  logic        update_out, busy, overflow, invalid;

  int checks = 0;
  int errors = 0;

  cpp_internal_double_to_int_convert #(.OUT_WIDTH(32), .SHIFT_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .update_in(update_in),
    .out(out), .update_out(update_out), .busy(busy),
    .overflow(overflow), .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts edges until update_out reaches lvl; reports busy dropping early.
  task automatic wait_upd(input logic lvl, output int edges, output int busy_drop);
    edges = 0;
    busy_drop = 0;
    while (update_out !== lvl && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (update_out !== lvl && !busy) busy_drop++;
    end
    check("update_seen", 64'(update_out), 64'(lvl));
  endtask

  task automatic convert(input string tag, input logic [63:0] val, input int n,
                         input logic [31:0] exp_out, input logic exp_ovf, input logic exp_inv);
    logic lvl;
    int   edges, drop;
    @(negedge clk);
    in = val;
    update_in = ~update_in;
    lvl = update_in;
    @(posedge clk); #1;
    check({tag, "_busy_cap"}, 64'(busy), 64'(1));
    wait_upd(lvl, edges, drop);
    check({tag, "_latency"}, 64'(edges), 64'(n + 1));
    check({tag, "_busy_held"}, 64'(drop), 64'(0));
    check({tag, "_out"}, 64'(out), 64'(exp_out));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    check({tag, "_inv"}, 64'(invalid), 64'(exp_inv));
    check({tag, "_busy_done"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic l1, l2;
    int   e, d, changes;
    logic prev;

    rst_n = 1'b0;
    in = 64'd0;
    update_in = 1'b0;
    #3;
    check("rst_out", 64'(out), 64'(0));
    check("rst_flags", {60'd0, update_out, busy, overflow, invalid}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Slow path and fast-path vectors.
    convert("one",      64'h3FF0000000000000, 7, 32'h00000001, 1'b0, 1'b0);
    convert("m2p75",    64'hC006000000000000, 7, 32'hFFFFFFFE, 1'b0, 1'b0);
    convert("hundred",  64'h4059000000000000, 6, 32'h00000064, 1'b0, 1'b0);
    convert("maxpos",   64'h41DFFFFFFFC00000, 3, 32'h7FFFFFFF, 1'b0, 1'b0);
    convert("three_e9", 64'h41E65A0BC0000000, 0, 32'h7FFFFFFF, 1'b1, 1'b0);
    convert("minneg",   64'hC1E0000000000000, 0, 32'h80000000, 1'b0, 1'b0);
    convert("neg_inf",  64'hFFF0000000000000, 0, 32'h80000000, 1'b1, 1'b0);
    convert("nan",      64'h7FF8000000000000, 0, 32'h00000000, 1'b0, 1'b1);
    convert("half",     64'h3FE0000000000000, 0, 32'h00000000, 1'b0, 1'b0);
    convert("neg_zero", 64'h8000000000000000, 0, 32'h00000000, 1'b0, 1'b0);

    // Single toggle while busy: queued conversion uses the input present after FINISH.
    @(negedge clk);
    in = 64'h3FF0000000000000;
    update_in = ~update_in;
    l1 = update_in;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in = 64'h4059000000000000;
    update_in = ~update_in;
    l2 = update_in;
    wait_upd(l1, e, d);
    check("busy1_lat", 64'(e), 64'(5));
    check("busy1_out", 64'(out), 64'(1));
    wait_upd(l2, e, d);
    check("busy2_lat", 64'(e), 64'(8));
    check("busy2_out", 64'(out), 64'(100));
    check("busy2_track", 64'(update_out), 64'(update_in));

    // Double toggle while busy coalesces into nothing.
    @(negedge clk);
    in = 64'h3FF0000000000000;
    update_in = ~update_in;
    l1 = update_in;
    @(posedge clk); #1;
    @(negedge clk);
    update_in = ~update_in;
    @(negedge clk);
    update_in = ~update_in;
    wait_upd(l1, e, d);
    prev = update_out;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (update_out !== prev) changes++;
      prev = update_out;
    end
    check("dbl_changes", 64'(changes), 64'(0));
    check("dbl_idle", 64'(busy), 64'(0));

    // Reset during SHIFT aborts with no update_out toggle.
    @(negedge clk);
    in = 64'h3FF0000000000000;
    update_in = ~update_in;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    update_in = 1'b0;
    #1;
    check("abort_out", 64'(out), 64'(0));
    check("abort_flags", {60'd0, update_out, busy, overflow, invalid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_upd", 64'(update_out), 64'(0));
    check("abort_idle", 64'(busy), 64'(0));
    convert("post_rst", 64'hC006000000000000, 7, 32'hFFFFFFFE, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
